// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the BCD display sequencer:
//   - state_e      : conversion FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   - SEG_0..SEG_9 : active-low segment codes, DP off (bit 7 = DP, 6..0 = g..a)
//   - SEG_BLANK    : all segments off
//   - seg7_encode  : 4-bit BCD digit to segment code (10..15 -> blank)
//   - min_digits   : smallest decimal digit count able to hold 2^width - 1
// ----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Non-decimal codes cannot come out of the converter; they show as blank.
  function automatic logic [7:0] seg7_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Smallest d with 10^d > 2^width - 1.
  function automatic int min_digits(input int width);
    longint max_v;
    longint pow10;
    int     d;
    max_v = (longint'(1) << width) - longint'(1);
    pow10 = longint'(1);
    d     = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_v) begin
        pow10 = pow10 * longint'(10);
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// ----------------------------------------------------------------------------
// seg7_digit_enc
// Combinational single-digit seven-segment encoder.
//   digit_i [3:0] : BCD digit
//   blank_i       : force the digit dark (leading-zero blanking)
//   seg_o   [7:0] : active-low segment bus, bit 7 = DP (always off)
// ----------------------------------------------------------------------------
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Blank overrides the digit value.
  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      seg_o = seg7_encode(digit_i);
    end
  end

endmodule

// File: rtl/bcd_display_sequencer.sv
// ----------------------------------------------------------------------------
// bcd_display_sequencer
// Converts an unsigned binary value to BCD with a shift-add-3 (double-dabble)
// FSM and drives one active-low 8-bit segment bus per decimal digit.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake (ready only while idle)
//   in_value          : WIDTH-bit unsigned value
//   busy              : conversion in progress
//   done              : one-cycle pulse when bcd/hex update
//   bcd               : registered BCD result, digit 0 in [3:0]
//   hex               : registered segment buses, digit i in [8i+7:8i]
// ----------------------------------------------------------------------------
module bcd_display_sequencer
  import seg7_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   hex
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 4) begin : g_width_chk
    $error("bcd_display_sequencer: WIDTH must be at least 4");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
    $error("bcd_display_sequencer: DIGITS too small for WIDTH");
  end

  // Display contents for a value of zero: digit 0 shows 0, the rest follow BLANK_LZ.
  function automatic logic [8*DIGITS-1:0] hex_reset_val();
    logic [8*DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i > 0) && BLANK_LZ) begin
        v[8*i +: 8] = SEG_BLANK;
      end else begin
        v[8*i +: 8] = SEG_0;
      end
    end
    return v;
  endfunction

  localparam logic [8*DIGITS-1:0] HEX_RST = hex_reset_val();

  state_e                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [WIDTH-1:0]      shreg_q,   shreg_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
  logic [8*DIGITS-1:0]   hex_q,     hex_d;
  logic                  done_q,    done_d;
  logic                  ready_q;
  logic                  busy_q;

  logic [4*DIGITS-1:0]   corr_s;
  logic [DIGITS-1:0]     blank_s;
  logic [8*DIGITS-1:0]   seg_s;
  logic                  zero_above_s;

  // Add-3 correction of every scratch digit >= 5 ahead of the shift.
  // A digit is at most 9 here, so the result fits in 4 bits.
  always_comb begin
    corr_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        corr_s[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end else begin
        corr_s[4*i +: 4] = scratch_q[4*i +: 4];
      end
    end
  end

  // Leading-zero blanking: scan from the top digit down; a digit blanks only
  // while it and every digit above it are zero. Digit 0 is always shown.
  always_comb begin
    blank_s      = '0;
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (scratch_q[4*i +: 4] == 4'd0);
      blank_s[i]   = BLANK_LZ & zero_above_s & (i > 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_digit_enc u_enc (
      .digit_i (scratch_q[4*g +: 4]),
      .blank_i (blank_s[g]),
      .seg_o   (seg_s[8*g +: 8])
    );
  end

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    hex_d     = hex_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && ready_q) begin
          shreg_d   = in_value;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {scratch_d, shreg_d} = {corr_s[4*DIGITS-2:0], shreg_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Outputs change only here, so the display never shows partial results.
        bcd_d   = scratch_q;
        hex_d   = seg_s;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rst wins over any accept in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      hex_q     <= HEX_RST;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      hex_q     <= hex_d;
      done_q    <= done_d;
      ready_q   <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign hex      = hex_q;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bcd_display_sequencer
// Drives two instances (leading-zero blanking on and off) with the same
// stimulus and compares them against a decimal-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_bcd_display_sequencer;

  localparam int W = 8;
  localparam int D = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_value;

  logic          in_ready_a, busy_a, done_a;
  logic [4*D-1:0] bcd_a;
  logic [8*D-1:0] hex_a;
  logic          in_ready_b, busy_b, done_b;
  logic [4*D-1:0] bcd_b;
  logic [8*D-1:0] hex_b;

  int errors = 0;
  int checks = 0;

  logic [23:0] prev_a;
  logic [23:0] prev_b;

  bcd_display_sequencer #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_value(in_value), .busy(busy_a), .done(done_a), .bcd(bcd_a), .hex(hex_a)
  );

  bcd_display_sequencer #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1'b0)) dut_nolz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_value(in_value), .busy(busy_b), .done(done_b), .bcd(bcd_b), .hex(hex_b)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] seg_ref(input int d);
    logic [7:0] tab [10];
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tab[d];
  endfunction

  function automatic logic [11:0] exp_bcd(input int v);
    logic [3:0] d0, d1, d2;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    return {d2, d1, d0};
  endfunction

  // Digit i > 0 is dark when the value is below 10^i (all digits from i up are 0).
  function automatic logic [23:0] exp_hex(input int v, input bit blz);
    logic [23:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      if (blz && (i > 0) && (v < p)) r[8*i +: 8] = 8'hFF;
      else                           r[8*i +: 8] = seg_ref((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single handshake + full observation of one conversion.
  task automatic convert(input int v);
    int n;
    int busy_n;
    int rdy_bad;
    int flick;
    int done_at;
    n = 0;
    while (!in_ready_a && n < 30) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_value = W'(v);
    tick();                         // accept edge E0
    in_valid = 1'b0;
    in_value = W'($urandom);
    busy_n = 0; rdy_bad = 0; flick = 0; done_at = -1;
    for (int k = 0; k <= 20 && done_at < 0; k++) begin
      if (done_a) begin
        done_at = k;
      end else begin
        if (busy_a) busy_n++;
        if (in_ready_a) rdy_bad++;
        if (hex_a !== prev_a || hex_b !== prev_b) flick++;
        tick();
      end
    end
    chk($sformatf("latency(%0d)", v), done_at, W + 1);
    chk($sformatf("busy_cycles(%0d)", v), busy_n, W + 1);
    chk($sformatf("ready_low(%0d)", v), rdy_bad, 0);
    chk($sformatf("no_flicker(%0d)", v), flick, 0);
    chk($sformatf("done_b(%0d)", v), done_b, 1);
    chk($sformatf("bcd(%0d)", v), bcd_a, exp_bcd(v));
    chk($sformatf("hex_lz(%0d)", v), hex_a, exp_hex(v, 1'b1));
    chk($sformatf("hex_nolz(%0d)", v), hex_b, exp_hex(v, 1'b0));
    tick();
    chk($sformatf("done_1cyc(%0d)", v), done_a, 0);
    chk($sformatf("ready_back(%0d)", v), in_ready_a, 1);
    prev_a = exp_hex(v, 1'b1);
    prev_b = exp_hex(v, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, in_ready_a, 1);
    chk({tag, "_busy"},  busy_a, 0);
    chk({tag, "_done"},  done_a, 0);
    chk({tag, "_bcd"},   bcd_a, 0);
    chk({tag, "_hex"},   hex_a, 24'hFFFFC0);
    chk({tag, "_hex_b"}, hex_b, 24'hC0C0C0);
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;
    logic [23:0] hex_first;
    logic [23:0] hex_second;

    // Reset with in_valid asserted: nothing must be accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    in_value = 8'd123;
    tick();
    tick();
    chk_reset_state("rst");
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_reset_state("post_rst");
    prev_a = 24'hFFFFC0;
    prev_b = 24'hC0C0C0;

    // Directed values.
    convert(255);
    chk("hex255", hex_a, 24'hA49292);
    convert(100);
    chk("hex100", hex_a, 24'hF9C0C0);
    convert(7);
    chk("hex7_lz", hex_a, 24'hFFFFF8);
    chk("hex7_nolz", hex_b, 24'hC0C0F8);
    convert(0);
    convert(10);

    // Random values against the model.
    for (int i = 0; i < 12; i++) begin
      convert(int'($urandom_range(0, 255)));
    end

    // Back-to-back: in_valid held; 200 is presented during 42's conversion.
    in_valid = 1'b1;
    in_value = 8'd42;
    tick();                         // accept 42 at E0
    in_value = 8'd200;
    first_done = -1; second_done = -1; hex_first = '0; hex_second = '0;
    for (int n = 0; n <= 24; n++) begin
      if (done_a) begin
        if (first_done < 0) begin
          first_done = n;
          hex_first  = hex_a;
        end else if (second_done < 0) begin
          second_done = n;
          hex_second  = hex_a;
        end
      end
      if (n == W + 2) in_valid = 1'b0;  // 200 accepted at this edge
      tick();
    end
    chk("b2b_first_at", first_done, W + 1);
    chk("b2b_gap", second_done - first_done, W + 2);
    chk("b2b_hex42", hex_first, 24'hFFA4 | 24'hFF0000 & 24'hFF0000 ? exp_hex(42, 1'b1) : 24'h0);
    chk("b2b_hex200", hex_second, exp_hex(200, 1'b1));
    chk("b2b_bcd200", bcd_a, 12'h200);
    prev_a = exp_hex(200, 1'b1);
    prev_b = exp_hex(200, 1'b0);

    // Reset mid-conversion.
    convert(42);
    in_valid = 1'b1;
    in_value = 8'd255;
    tick();                         // E0
    in_valid = 1'b0;
    tick(); tick(); tick();         // E1..E3
    chk("midrst_busy", busy_a, 1);
    rst = 1'b1;
    tick();                         // E4
    chk_reset_state("midrst");
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      if (done_a || done_b) done_cnt++;
      tick();
    end
    chk("midrst_no_done", done_cnt, 0);
    prev_a = 24'hFFFFC0;
    prev_b = 24'hC0C0C0;
    convert(9);
    chk("hex9_after_rst", hex_a, 24'hFFFF90);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_display_sequencer.md
# bcd_display_sequencer

Sequential binary-to-decimal display controller for the seven-segment outputs. It accepts an unsigned binary value through a valid/ready handshake and converts it to BCD with a multi-cycle shift-add-3 (double-dabble) state machine. It drives one active-low 8-bit segment bus per decimal digit. It replaces the purely combinational 4-bit comparator/decoder path and scales to wider switch inputs and more digits.

## Interface
- WIDTH, 8: binary input width, ≥ 4.
- DIGITS, 3: number of decimal digits. Requires 10^DIGITS > 2^WIDTH − 1.
- BLANK_LZ, 1: 1 blanks leading zeros. Digit 0 is never blanked.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_value is offered.
- in_ready  out  1  block can accept a value. High only in IDLE.
- in_value  in  WIDTH  unsigned binary value.
- busy  out  1  conversion in progress (SHIFT or DONE state).
- done  out  1  one-cycle pulse when outputs update.
- bcd  out  4*DIGITS  registered BCD result. Digit 0 is bits [3:0].
- hex  out  8*DIGITS  registered segment buses. Digit i is bits [8i+7:8i]. Active-low; bit 7 is DP; bits 6..0 are g..a.

## Operation
- FSM states: IDLE → SHIFT → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready, capture in_value into the shift register, clear the BCD scratch register, load cnt = WIDTH, and go to SHIFT.
- SHIFT, once per cycle:
  - Add 3 to every scratch digit ≥ 5.
  - Shift {scratch, shreg} left by 1.
  - Decrement cnt.
  - When cnt reaches 0 after this shift, go to DONE.
- DONE:
  - Latch scratch into bcd.
  - Encode every digit into hex.
  - Pulse done.
  - Go to IDLE.
- Segment encoding (active-low, DP off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Blank = FF. Codes 10–15 encode as blank; they are unreachable.
- Leading-zero blanking (BLANK_LZ=1): digit i > 0 is blank when it and every higher digit are 0. An interior zero is shown.
- hex and bcd hold their previous value for the whole conversion. There is no intermediate flicker.
- in_valid while busy is ignored. No value is queued, and the source must hold in_valid until in_ready.
- Arithmetic: scratch digits are 4-bit. The add-3 never overflows because a digit is ≤ 9 before correction.

## Timing
- Reset values:
  - State IDLE, in_ready = 1, busy = 0, done = 0, bcd = 0.
  - hex digit 0 = C0. Higher digits = FF when BLANK_LZ=1, otherwise C0.
- Latency, with the accept edge as E0:
  - SHIFT occupies edges E1..E_WIDTH.
  - bcd, hex and done update at edge E_{WIDTH+1}. done is high for exactly one cycle.
  - in_ready is high again after E_{WIDTH+1}.
- Throughput: one conversion per WIDTH+2 cycles when in_valid is held high.
- rst asserted mid-conversion aborts at the next edge. All outputs return to their reset values and no done pulse is issued.
- rst has priority over every simultaneous event, including an accept.

## Structure
- Shared package seg7_pkg holds:
  - The FSM state enum.
  - Segment constants: SEG_0..SEG_9 and SEG_BLANK = 8'hFF.
  - A function that returns the minimum DIGITS for a given WIDTH, used for an elaboration check.
- Sub-module seg7_digit_enc: combinational 4-bit BCD plus blank flag in, 8-bit active-low bus out. It is instantiated DIGITS times.
- The FSM, cnt ($clog2(WIDTH+1) bits) and the shift/scratch registers live in the top-level module.

## Test plan
- Reset then idle:
  - Required: hex = FF_FF_C0, bcd = 000, in_ready = 1, done = 0.
  - Also check that in_valid held for 2 cycles during reset is not accepted.
- Accept 255:
  - Required: done pulses exactly WIDTH+1 = 9 edges after accept, bcd = 0x255, hex = A4_92_92.
  - Required: busy is high for 9 cycles and in_ready is low during them.
- Accept 100:
  - Required: bcd = 0x100, hex = F9_C0_C0, which proves interior zeros are not blanked.
- Accept 7 with BLANK_LZ=1:
  - Required: hex = FF_FF_F8.
  - Rerun with BLANK_LZ=0. Required: hex = C0_C0_F8.
- Back-to-back:
  - Hold in_valid with 42 and then 200.
  - Required: two done pulses 10 cycles apart, with hex showing 42 and then 200.
  - Required: a different in_value driven mid-conversion is ignored.
- Reset mid-conversion:
  - Accept 255 with hex previously showing 42, then assert rst at edge E4.
  - Required: no done pulse, outputs return to reset values, and the next accept of 9 yields hex = FF_FF_90.
